// File: rtl/vga_pkg.sv
`default_nettype none
// ==================================================================
// vga_pkg : VGA geometry constants, RGB pixel type, scale clamp helper
// Rev 1.0
// ==================================================================
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic logic [1:0] clamp_scale(input logic [1:0] s, input int max_scl);
    if (int'(s) > max_scl) return 2'(max_scl);
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_addr_gen.sv
`default_nettype none
// ==================================================================
// sprite_addr_gen : frame-start config latch, window test, scale/mirror, ROM address
// Rev 1.0
// ==================================================================
module sprite_addr_gen
  import vga_pkg::*;
#(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int ADDR_W  = 16,
  parameter int MAX_SCL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              video_on,
  input  logic [9:0]        origin_x,
  input  logic [9:0]        origin_y,
  input  logic [1:0]        scale_log2,
  input  logic              mirror_x,
  input  logic              key_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              in_win,
  output logic              key_act
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  logic [9:0]       cfg_ox, cfg_oy;
  logic [1:0]       cfg_scl;
  logic             cfg_mir, cfg_key;
  logic             frame_start;
  logic [9:0]       ox, oy;
  logic [1:0]       scl;
  logic             mir, key;
  logic [10:0]      dx, dy;
  logic [12:0]      ext_w, ext_h;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             win;

  assign frame_start = pix_en && (x == 10'd0) && (y == 10'd0);

  // The frame-start pixel itself already renders with the freshly sampled config.
  always_comb begin
    ox  = frame_start ? origin_x : cfg_ox;
    oy  = frame_start ? origin_y : cfg_oy;
    scl = frame_start ? clamp_scale(scale_log2, MAX_SCL) : cfg_scl;
    mir = frame_start ? mirror_x : cfg_mir;
    key = frame_start ? key_en   : cfg_key;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_ox  <= '0;
      cfg_oy  <= '0;
      cfg_scl <= '0;
      cfg_mir <= 1'b0;
      cfg_key <= 1'b0;
    end else if (frame_start) begin
      cfg_ox  <= ox;
      cfg_oy  <= oy;
      cfg_scl <= scl;
      cfg_mir <= mir;
      cfg_key <= key;
    end
  end

  // Bit 10 of the differences is the sign: left/above the origin is never in the window.
  always_comb begin
    dx    = {1'b0, x} - {1'b0, ox};
    dy    = {1'b0, y} - {1'b0, oy};
    ext_w = 13'(IMG_W) << scl;
    ext_h = 13'(IMG_H) << scl;
    win   = video_on && !dx[10] && !dy[10] &&
            ({3'b000, dx[9:0]} < ext_w) && ({3'b000, dy[9:0]} < ext_h);
    col   = COL_W'(dx[9:0] >> scl);
    row   = ROW_W'(dy[9:0] >> scl);
    if (mir) col = ~col;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      in_win   <= 1'b0;
      key_act  <= 1'b0;
    end else if (pix_en) begin
      rom_addr <= win ? ADDR_W'({row, col}) : '0;
      in_win   <= win;
      key_act  <= key;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_sprite_renderer.sv
`default_nettype none
// ==================================================================
// vga_sprite_renderer : positioned/scaled/mirrored ROM sprite with colour key, sync-aligned
// Rev 1.0
// ==================================================================
module vga_sprite_renderer
  import vga_pkg::*;
#(
  parameter int               IMG_W     = 256,
  parameter int               IMG_H     = 256,
  parameter int               ADDR_W    = 16,
  parameter int               PIX_W     = 24,
  parameter int               ROM_LAT   = 1,
  parameter int               MAX_SCL   = 2,
  parameter logic [PIX_W-1:0] BG_COLOR  = 24'h000000,
  parameter logic [PIX_W-1:0] KEY_COLOR = 24'hFF00FF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              video_on,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic [9:0]        origin_x,
  input  logic [9:0]        origin_y,
  input  logic [1:0]        scale_log2,
  input  logic              mirror_x,
  input  logic              key_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              hs_out,
  output logic              vs_out,
  output logic              blank_n
);

  // Raw video_on/syncs skip the address stage, so they need one extra delay slot.
  localparam int SYNC_D = ROM_LAT + 1;

  logic               win_a, key_a;
  logic [ROM_LAT-1:0] win_sr, key_sr;
  logic [SYNC_D-1:0]  von_sr, hs_sr, vs_sr;
  rgb_t               pix;

  sprite_addr_gen #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .ADDR_W  (ADDR_W),
    .MAX_SCL (MAX_SCL)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .x          (x),
    .y          (y),
    .video_on   (video_on),
    .origin_x   (origin_x),
    .origin_y   (origin_y),
    .scale_log2 (scale_log2),
    .mirror_x   (mirror_x),
    .key_en     (key_en),
    .rom_addr   (rom_addr),
    .in_win     (win_a),
    .key_act    (key_a)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_sr <= '0;
      key_sr <= '0;
      von_sr <= '0;
      hs_sr  <= '1;
      vs_sr  <= '1;
    end else if (pix_en) begin
      win_sr <= ROM_LAT'({win_sr, win_a});
      key_sr <= ROM_LAT'({key_sr, key_a});
      von_sr <= SYNC_D'({von_sr, video_on});
      hs_sr  <= SYNC_D'({hs_sr, hs_in});
      vs_sr  <= SYNC_D'({vs_sr, vs_in});
    end
  end

  always_comb begin
    pix = rgb_t'(rom_data);
    if (!von_sr[SYNC_D-1])
      pix = '0;
    else if (!win_sr[ROM_LAT-1] || (key_sr[ROM_LAT-1] && (rom_data == KEY_COLOR)))
      pix = rgb_t'(BG_COLOR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r       <= '0;
      g       <= '0;
      b       <= '0;
      hs_out  <= 1'b1;
      vs_out  <= 1'b1;
      blank_n <= 1'b0;
    end else if (pix_en) begin
      r       <= pix.r;
      g       <= pix.g;
      b       <= pix.b;
      hs_out  <= hs_sr[SYNC_D-1];
      vs_out  <= vs_sr[SYNC_D-1];
      blank_n <= von_sr[SYNC_D-1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_sprite_renderer.sv
`default_nettype none
// ==================================================================
// tb_vga_sprite_renderer : scoreboard bench with a pixel-level reference model
// Rev 1.0
// ==================================================================
module tb_vga_sprite_renderer;

  localparam int          ROM_LAT = 1;
  localparam logic [23:0] BG      = 24'h203040;
  localparam logic [23:0] KEY     = 24'hFF00FF;

  typedef struct {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        bl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, pix_en, video_on, hs_in, vs_in, mirror_x, key_en;
  logic [9:0]  x, y, origin_x, origin_y;
  logic [1:0]  scale_log2;
  logic [15:0] rom_addr;
  logic [23:0] rom_data = '0;
  logic [7:0]  r, g, b;
  logic        hs_out, vs_out, blank_n;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  logic [15:0] addr_q[$];
  exp_t last_e;
  logic [15:0] last_a = '0;

  int m_ox, m_oy, m_s;
  bit m_mir, m_key;

  vga_sprite_renderer #(
    .ROM_LAT   (ROM_LAT),
    .BG_COLOR  (BG),
    .KEY_COLOR (KEY)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .x(x), .y(y), .video_on(video_on),
    .hs_in(hs_in), .vs_in(vs_in), .origin_x(origin_x), .origin_y(origin_y),
    .scale_log2(scale_log2), .mirror_x(mirror_x), .key_en(key_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .r(r), .g(g), .b(b),
    .hs_out(hs_out), .vs_out(vs_out), .blank_n(blank_n)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] rom_word(input logic [15:0] a);
    if (a % 13 == 3) return KEY;
    return {a[7:0] ^ 8'hA5, a[15:8], a[7:0] + a[15:8]};
  endfunction

  always_ff @(posedge clk) if (pix_en) rom_data <= rom_word(rom_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    exp_t e;
    exp_q.delete();
    addr_q.delete();
    e.rgb = '0; e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0;
    for (int i = 0; i < ROM_LAT + 1; i++) exp_q.push_back(e);
    m_ox = 0; m_oy = 0; m_s = 0; m_mir = 0; m_key = 0;
  endtask

  task automatic set_cfg(input int ox, input int oy, input int sc, input bit mir, input bit key);
    origin_x = 10'(ox); origin_y = 10'(oy); scale_log2 = 2'(sc); mirror_x = mir; key_en = key;
  endtask

  // Called at a falling edge; presents one pixel tick and records what it must produce.
  task automatic drive(input int xx, input int yy, input bit von);
    exp_t e;
    int dx, dy, sc, col, row, addr;
    bit inwin;
    logic [23:0] word;
    x = 10'(xx); y = 10'(yy); video_on = von;
    hs_in = 1'($urandom); vs_in = 1'($urandom); pix_en = 1'b1;
    if (xx == 0 && yy == 0) begin
      m_ox = int'(origin_x); m_oy = int'(origin_y);
      m_s = (scale_log2 > 2) ? 2 : int'(scale_log2);
      m_mir = mirror_x; m_key = key_en;
    end
    sc = 1 << m_s;
    dx = xx - m_ox;
    dy = yy - m_oy;
    inwin = von && dx >= 0 && dy >= 0 && dx < 256 * sc && dy < 256 * sc;
    addr = 0;
    if (inwin) begin
      col = dx / sc;
      row = dy / sc;
      if (m_mir) col = 255 - col;
      addr = row * 256 + col;
    end
    word = rom_word(16'(addr));
    if (!von) e.rgb = '0;
    else if (!inwin || (m_key && word == KEY)) e.rgb = BG;
    else e.rgb = word;
    e.hs = hs_in; e.vs = vs_in; e.bl = von;
    exp_q.push_back(e);
    addr_q.push_back(16'(addr));
    @(negedge clk);
    pix_en = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: compares DUT outputs after every pixel tick against the scoreboard queues.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst && pix_en) begin
        #1;
        if (addr_q.size() > 0) begin
          last_a = addr_q.pop_front();
          chk("rom_addr", 32'(rom_addr), 32'(last_a));
        end
        if (exp_q.size() >= ROM_LAT + 2) begin
          e = exp_q.pop_front();
          last_e = e;
          chk("pixel{rgb,hs,vs,blank_n}", {5'b0, r, g, b, hs_out, vs_out, blank_n},
              {5'b0, e.rgb, e.hs, e.vs, e.bl});
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int ox, oy, xx, yy;
    rst = 1'b1; pix_en = 1'b0; x = '0; y = '0; video_on = 1'b0;
    hs_in = 1'b1; vs_in = 1'b1;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset rom_addr", 32'(rom_addr), 32'h0);
    chk("reset rgb", {8'h0, r, g, b}, 32'h0);
    chk("reset hs/vs/blank_n", {29'h0, hs_out, vs_out, blank_n}, 32'h6);
    reset_model();
    rst = 1'b0;
    @(negedge clk);

    // Origin 0, scale 0: address pattern and keyed word shown as-is with key off.
    set_cfg(0, 0, 0, 0, 0);
    drive(0, 0, 1); drive(5, 2, 1); drive(3, 0, 1);
    set_cfg(0, 0, 0, 0, 1);
    drive(3, 0, 1); drive(0, 0, 1); drive(3, 0, 1); drive(4, 0, 1);
    // Mirror.
    set_cfg(0, 0, 0, 1, 0);
    drive(0, 0, 1); drive(255, 0, 1); drive(256, 0, 1); drive(1, 1, 1);
    // Origin (100,50) scale 1, window edges; also a clamped scale value.
    set_cfg(100, 50, 1, 0, 0);
    drive(0, 0, 1); drive(99, 50, 1); drive(100, 50, 1); drive(101, 51, 1);
    drive(102, 52, 1); drive(611, 50, 1); drive(612, 50, 1); drive(100, 561, 1);
    drive(150, 60, 0);
    set_cfg(0, 0, 3, 0, 0);
    drive(0, 0, 1); drive(1023, 479, 1); drive(7, 9, 1);
    // Mid-frame origin change only takes effect at the next frame start.
    set_cfg(0, 0, 0, 0, 0);
    drive(0, 0, 1); drive(300, 100, 1);
    set_cfg(200, 0, 0, 0, 0);
    drive(250, 100, 1); drive(10, 101, 1); drive(0, 0, 1); drive(150, 10, 1); drive(200, 0, 1);

    for (int n = 0; n < 3000; n++) begin
      if (n % 97 == 0) begin
        set_cfg($urandom_range(0, 400), $urandom_range(0, 300), $urandom_range(0, 3),
                1'($urandom), 1'($urandom));
        drive(0, 0, 1);
      end else begin
        if ($urandom_range(0, 3) == 0)
          set_cfg($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 3),
                  1'($urandom), 1'($urandom));
        xx = $urandom_range(1, 799);
        yy = $urandom_range(0, 524);
        drive(xx, yy, (xx < 640 && yy < 480) ? ($urandom_range(0, 15) != 0) : 1'b0);
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);

      if (n == 1000) begin
        for (int i = 0; i < 10; i++) begin
          x = 10'($urandom); y = 10'($urandom); video_on = 1'($urandom);
          hs_in = 1'($urandom); vs_in = 1'($urandom);
          @(negedge clk);
          chk("frozen rom_addr", 32'(rom_addr), 32'(last_a));
          chk("frozen pixel", {5'b0, r, g, b, hs_out, vs_out, blank_n},
              {5'b0, last_e.rgb, last_e.hs, last_e.vs, last_e.bl});
        end
      end

      if (n == 2000) begin
        #3 rst = 1'b1;
        #1;
        chk("midline reset rgb", {8'h0, r, g, b}, 32'h0);
        chk("midline reset hs/vs/blank_n", {29'h0, hs_out, vs_out, blank_n}, 32'h6);
        chk("midline reset rom_addr", 32'(rom_addr), 32'h0);
        reset_model();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // Default config applies until the next frame start.
        ox = 0; oy = 0;
        set_cfg(300, 300, 2, 1, 1);
        drive(ox + 10, oy + 20, 1); drive(1, 0, 1); drive(300, 300, 1);
      end
    end

    for (int i = 0; i < ROM_LAT + 2; i++) drive(700, 500, 0);
    chk("scoreboard residue", 32'(exp_q.size()), 32'(ROM_LAT + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
